// File: rtl/upd7800_bus_target.sv
// Bus responder for the uPD7800 external bus: a 128-byte RAM window plus a
// 16-bit opcode-fetch (M1) counter exposed as two byte registers.
module upd7800_bus_target #(
  parameter logic [15:0] RAM_BASE = 16'hFF80,
  parameter logic [15:0] CTR_ADDR = 16'hFF7E
) (
  input  logic        clk_i,
  input  logic        resetb_i,
  input  logic        cp1_posedge_i,
  input  logic        cp2_posedge_i,
  input  logic        cp2_negedge_i,
  input  logic [15:0] a_i,
  input  logic [7:0]  db_i,
  input  logic        cpu_db_oe_i,
  input  logic        m1_i,
  output logic [7:0]  db_o,
  output logic        db_oe_o,
  output logic        hit_o
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_e;

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] ctr_q, ctr_d;
  logic [7:0]  db_q, db_d;
  logic [7:0]  shadow_q, shadow_d;
  logic        db_oe_q, db_oe_d;
  logic        hit_q, hit_d;
  logic        prev_m1_q, prev_m1_d;
  logic [7:0]  ram_q [128];
  logic        ram_we;
  logic        ctr_clr;
  logic        a_ram_hit, a_ctr_hit;
  logic        q_ram_hit, q_ctr_hit;
  logic [7:0]  rd_data;
  logic        unused_cp1;

  // CP1 is part of the core's phase interface but nothing here depends on it.
  assign unused_cp1 = cp1_posedge_i;

  assign a_ram_hit = (a_i[15:7] == RAM_BASE[15:7]);
  assign a_ctr_hit = (a_i[15:1] == CTR_ADDR[15:1]);
  assign q_ram_hit = (addr_q[15:7] == RAM_BASE[15:7]);
  assign q_ctr_hit = (addr_q[15:1] == CTR_ADDR[15:1]);

  always_comb begin
    rd_data = 8'h00;
    if (a_ram_hit) begin
      rd_data = ram_q[a_i[6:0]];
    end else if (a_ctr_hit) begin
      rd_data = a_i[0] ? shadow_q : ctr_q[7:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    db_d      = db_q;
    db_oe_d   = db_oe_q;
    hit_d     = hit_q;
    shadow_d  = shadow_q;
    prev_m1_d = prev_m1_q;
    ctr_d     = ctr_q;
    ram_we    = 1'b0;
    ctr_clr   = 1'b0;

    // A fresh CP2 rising edge always re-decodes, abandoning any unfinished cycle.
    if (cp2_posedge_i) begin
      state_d = IDLE;
      db_oe_d = 1'b0;
      hit_d   = 1'b0;
      if (a_ram_hit || a_ctr_hit) begin
        addr_d = a_i;
        hit_d  = 1'b1;
        if (cpu_db_oe_i) begin
          state_d = WR;
        end else begin
          state_d = RD;
          db_d    = rd_data;
          db_oe_d = 1'b1;
          if (a_ctr_hit && !a_i[0]) begin
            shadow_d = ctr_q[15:8];
          end
        end
      end
    end else if (cp2_negedge_i) begin
      case (state_q)
        RD: begin
          state_d = IDLE;
          db_oe_d = 1'b0;
          hit_d   = 1'b0;
        end
        WR: begin
          state_d = IDLE;
          hit_d   = 1'b0;
          ram_we  = q_ram_hit;
          ctr_clr = q_ctr_hit;
        end
        default: ;
      endcase
    end

    if (cp2_negedge_i) begin
      prev_m1_d = m1_i;
      if (m1_i && !prev_m1_q) begin
        ctr_d = ctr_q + 16'd1;
      end
    end
    if (ctr_clr) begin
      ctr_d = 16'h0000;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetb_i) begin
      state_q   <= IDLE;
      addr_q    <= 16'h0000;
      db_q      <= 8'h00;
      db_oe_q   <= 1'b0;
      hit_q     <= 1'b0;
      shadow_q  <= 8'h00;
      prev_m1_q <= 1'b0;
      ctr_q     <= 16'h0000;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      db_q      <= db_d;
      db_oe_q   <= db_oe_d;
      hit_q     <= hit_d;
      shadow_q  <= shadow_d;
      prev_m1_q <= prev_m1_d;
      ctr_q     <= ctr_d;
    end
  end

  // RAM contents survive reset; reset only suppresses a pending write.
  always_ff @(posedge clk_i) begin
    if (resetb_i && ram_we) begin
      ram_q[addr_q[6:0]] <= db_i;
    end
  end

  assign db_o    = db_q;
  assign db_oe_o = db_oe_q;
  assign hit_o   = hit_q;

endmodule

// File: tb/tb_upd7800_bus_target.sv
// Self-checking bench for upd7800_bus_target: directed bus cycles followed by
// randomized cycles, all compared against a behavioural model of RAM and counter.
module tb_upd7800_bus_target;

  logic        clk = 1'b0;
  logic        resetb;
  logic        cp1;
  logic        cp2p;
  logic        cp2n;
  logic [15:0] a;
  logic [7:0]  dbIn;
  logic        cpuDbOe;
  logic        m1;
  logic [7:0]  dbOut;
  logic        dbOe;
  logic        hit;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  ramM [128];
  int unsigned ctrM;
  logic [7:0]  shadowM;
  bit          prevM1M;
  logic [7:0]  rd;

  always #5 clk = ~clk;

  upd7800_bus_target #(
    .RAM_BASE(16'hFF80),
    .CTR_ADDR(16'hFF7E)
  ) dut (
    .clk_i        (clk),
    .resetb_i     (resetb),
    .cp1_posedge_i(cp1),
    .cp2_posedge_i(cp2p),
    .cp2_negedge_i(cp2n),
    .a_i          (a),
    .db_i         (dbIn),
    .cpu_db_oe_i  (cpuDbOe),
    .m1_i         (m1),
    .db_o         (dbOut),
    .db_oe_o      (dbOe),
    .hit_o        (hit)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One core bus cycle: CP1, CP2 rise, a hold CLK, then CP2 fall (unless aborted).
  task automatic busCycle(input logic [15:0] addr, input bit wr, input logic [7:0] wdata,
                          input bit m1v, input bit abort, output logic [7:0] rdObs);
    bit ramHit, ctrHit, hitExp, rdExp, inc;
    logic [7:0] dataExp;
    ramHit  = (addr >= 16'hFF80);
    ctrHit  = (addr == 16'hFF7E) || (addr == 16'hFF7F);
    hitExp  = ramHit || ctrHit;
    rdExp   = hitExp && !wr;
    dataExp = 8'h00;
    if (rdExp) begin
      if (ramHit) dataExp = ramM[addr - 16'hFF80];
      else if (addr == 16'hFF7F) dataExp = shadowM;
      else begin
        dataExp = 8'(ctrM % 256);
        shadowM = 8'(ctrM / 256);
      end
    end
    @(negedge clk);
    a = addr; cpuDbOe = wr; dbIn = wdata; m1 = m1v; cp1 = 1'b1;
    @(negedge clk);
    cp1 = 1'b0; cp2p = 1'b1;
    @(negedge clk);
    cp2p = 1'b0;
    a = 16'($urandom);
    check("oe_rise", 16'(dbOe), 16'(rdExp));
    check("hit_rise", 16'(hit), 16'(hitExp));
    rdObs = dbOut;
    if (rdExp) check("rdata", 16'(dbOut), 16'(dataExp));
    @(negedge clk);
    check("oe_hold", 16'(dbOe), 16'(rdExp));
    check("hit_hold", 16'(hit), 16'(hitExp));
    if (rdExp) check("rdata_hold", 16'(dbOut), 16'(dataExp));
    if (abort) return;
    cp2n = 1'b1;
    @(negedge clk);
    cp2n = 1'b0;
    check("oe_fall", 16'(dbOe), 16'h0);
    check("hit_fall", 16'(hit), 16'h0);
    inc = m1v && !prevM1M;
    prevM1M = m1v;
    if (wr && ramHit) ramM[addr - 16'hFF80] = wdata;
    if (wr && ctrHit) ctrM = 0;
    else if (inc) ctrM = (ctrM + 1) % 65536;
  endtask

  task automatic applyFetches(input int n);
    logic [7:0] dummy;
    for (int i = 0; i < n; i++) begin
      busCycle(16'h0100, 1'b0, 8'h00, 1'b1, 1'b0, dummy);
      busCycle(16'h1234, 1'b0, 8'h00, 1'b0, 1'b0, dummy);
    end
  endtask

  initial begin
    logic [15:0] ra;
    resetb = 1'b0; cp1 = 1'b0; cp2p = 1'b0; cp2n = 1'b0;
    a = 16'h0000; dbIn = 8'h00; cpuDbOe = 1'b0; m1 = 1'b0;
    ctrM = 0; shadowM = 8'h00; prevM1M = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_oe", 16'(dbOe), 16'h0);
    check("rst_hit", 16'(hit), 16'h0);
    check("rst_dbo", 16'(dbOut), 16'h0);
    resetb = 1'b1;

    for (int i = 0; i < 128; i++)
      busCycle(16'hFF80 + 16'(i), 1'b1, 8'($urandom), 1'b0, 1'b0, rd);

    busCycle(16'hFF80, 1'b1, 8'hA5, 1'b0, 1'b0, rd);
    busCycle(16'hFFFF, 1'b1, 8'h3C, 1'b0, 1'b0, rd);
    busCycle(16'hFF80, 1'b0, 8'h00, 1'b0, 1'b0, rd);
    check("rd_ff80", 16'(rd), 16'h00A5);
    busCycle(16'hFFFF, 1'b0, 8'h00, 1'b0, 1'b0, rd);
    check("rd_ffff", 16'(rd), 16'h003C);

    busCycle(16'h1234, 1'b0, 8'h00, 1'b0, 1'b0, rd);
    busCycle(16'h1234, 1'b1, 8'hDE, 1'b0, 1'b0, rd);
    busCycle(16'hFF80, 1'b0, 8'h00, 1'b0, 1'b0, rd);
    check("ram_intact", 16'(rd), 16'h00A5);

    busCycle(16'hFF7E, 1'b1, 8'h55, 1'b0, 1'b0, rd);
    applyFetches(5);
    busCycle(16'hFF7E, 1'b0, 8'h00, 1'b0, 1'b0, rd);
    check("ctr_lo5", 16'(rd), 16'h0005);
    busCycle(16'hFF7F, 1'b0, 8'h00, 1'b0, 1'b0, rd);
    check("ctr_hi5", 16'(rd), 16'h0000);

    busCycle(16'hFF7E, 1'b1, 8'h00, 1'b0, 1'b0, rd);
    applyFetches(255);
    busCycle(16'hFF7E, 1'b0, 8'h00, 1'b0, 1'b0, rd);
    check("ctr_lo_ff", 16'(rd), 16'h00FF);
    applyFetches(1);
    busCycle(16'hFF7F, 1'b0, 8'h00, 1'b0, 1'b0, rd);
    check("shadow_hi", 16'(rd), 16'h0000);
    busCycle(16'hFF7E, 1'b0, 8'h00, 1'b0, 1'b0, rd);
    check("ctr_lo_100", 16'(rd), 16'h0000);
    busCycle(16'hFF7F, 1'b0, 8'h00, 1'b0, 1'b0, rd);
    check("ctr_hi_100", 16'(rd), 16'h0001);

    @(negedge clk);
    force dut.ctr_q = 16'hFFFF;
    @(negedge clk);
    release dut.ctr_q;
    ctrM = 65535;
    applyFetches(1);
    busCycle(16'hFF7E, 1'b0, 8'h00, 1'b0, 1'b0, rd);
    check("wrap_lo", 16'(rd), 16'h0000);
    busCycle(16'hFF7F, 1'b0, 8'h00, 1'b0, 1'b0, rd);
    check("wrap_hi", 16'(rd), 16'h0000);

    applyFetches(1);
    busCycle(16'hFF7F, 1'b1, 8'h5A, 1'b1, 1'b0, rd);
    busCycle(16'hFF7E, 1'b0, 8'h00, 1'b0, 1'b0, rd);
    check("clr_win_lo", 16'(rd), 16'h0000);
    busCycle(16'hFF7F, 1'b0, 8'h00, 1'b0, 1'b0, rd);
    check("clr_win_hi", 16'(rd), 16'h0000);

    busCycle(16'hFF85, 1'b1, 8'h11, 1'b0, 1'b0, rd);
    busCycle(16'hFF85, 1'b1, 8'h99, 1'b0, 1'b1, rd);
    busCycle(16'hFF85, 1'b0, 8'h00, 1'b0, 1'b0, rd);
    check("abort_wr", 16'(rd), 16'h0011);

    busCycle(16'hFF90, 1'b1, 8'h77, 1'b0, 1'b0, rd);
    @(negedge clk);
    a = 16'hFF90; cpuDbOe = 1'b1; dbIn = 8'hEE; m1 = 1'b0; cp1 = 1'b1;
    @(negedge clk);
    cp1 = 1'b0; cp2p = 1'b1;
    @(negedge clk);
    cp2p = 1'b0;
    check("rstwr_hit", 16'(hit), 16'h1);
    resetb = 1'b0;
    @(negedge clk);
    resetb = 1'b1;
    check("rstwr_oe", 16'(dbOe), 16'h0);
    check("rstwr_hit0", 16'(hit), 16'h0);
    cp2n = 1'b1;
    @(negedge clk);
    cp2n = 1'b0;
    ctrM = 0; shadowM = 8'h00; prevM1M = 1'b0;
    busCycle(16'hFF90, 1'b0, 8'h00, 1'b0, 1'b0, rd);
    check("rstwr_ram", 16'(rd), 16'h0077);
    busCycle(16'hFF7E, 1'b0, 8'h00, 1'b0, 1'b0, rd);
    check("rst_ctr", 16'(rd), 16'h0000);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0:       ra = 16'hFF80 + 16'($urandom_range(0, 127));
        1:       ra = 16'hFF7E + 16'($urandom_range(0, 1));
        2:       ra = 16'hFF70 + 16'($urandom_range(0, 15));
        default: ra = 16'($urandom);
      endcase
      busCycle(ra, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 7) == 0), rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/upd7800_bus_target.md
Name: upd7800_bus_target

Overview:
- Bus responder for the uPD7800 core's external bus: samples the address the core drives, returns read data on the core's data input, and commits writes the core drives out.
- Contains a 128-byte internal RAM window plus a 16-bit opcode-fetch (M1) counter mapped as two byte registers.
- Uses the same CP1/CP2 phase-enable pulses as the core. Sits between the core and the system data-bus mux; its DB_OE selects it onto the core's DB_I.

Parameters:
- RAM_BASE, 16'hFF80, first address of the 128-byte RAM window; low 7 bits must be zero.
- CTR_ADDR, 16'hFF7E, address of counter low byte; CTR_ADDR+1 is the high byte; bit 0 must be zero.

Ports:
- CLK  input  1  system clock, single clock domain.
- RESETB  input  1  synchronous active-low reset.
- CP1_POSEDGE  input  1  phase-1 rising-edge enable pulse (one CLK wide).
- CP2_POSEDGE  input  1  phase-2 rising-edge enable pulse.
- CP2_NEGEDGE  input  1  phase-2 falling-edge enable pulse.
- A  input  16  address from core.
- DB_I  input  8  write data from core (core's DB_O).
- CPU_DB_OE  input  1  core is driving data (write cycle).
- M1  input  1  core opcode-fetch cycle indicator.
- DB_O  output  8  read data to core.
- DB_OE  output  1  this block is driving read data.
- HIT  output  1  current bus cycle decodes to this block (registered).

Behaviour:
- Reset: synchronous on CLK when RESETB=0. DB_O=0, DB_OE=0, HIT=0, state=IDLE, counter=0, shadow=0. RAM contents are not reset.
- Decode:
  - ram_hit = A[15:7]==RAM_BASE[15:7].
  - ctr_hit = A[15:1]==CTR_ADDR[15:1].
  - hit = ram_hit|ctr_hit.
- States: IDLE, RD, WR.
- IDLE, CLK with CP2_POSEDGE=1:
  - hit & ~CPU_DB_OE -> RD. Latch A into addr_q. Next CLK: DB_O = selected data, DB_OE=1, HIT=1.
  - hit & CPU_DB_OE -> WR, HIT=1, DB_OE stays 0.
  - no hit -> stay IDLE, HIT=0.
- RD:
  - DB_O and DB_OE are held stable.
  - On the CLK with CP2_NEGEDGE=1 -> IDLE; DB_OE=0 and HIT=0 from the next CLK.
  - The core samples DB_I on its CP2_NEGEDGE while DB_OE=1.
- WR:
  - On the CLK with CP2_NEGEDGE=1: sample DB_I.
  - RAM hit: RAM[addr_q[6:0]] <= DB_I.
  - Counter hit: counter cleared to 0, regardless of data.
  - Then -> IDLE, HIT=0.
- Timing requirement: at least one CLK between CP2_POSEDGE and CP2_NEGEDGE. The read path is one registered stage, so data is valid one CLK after CP2_POSEDGE.
- Read data:
  - RAM: RAM[A[6:0]].
  - CTR_ADDR: counter[7:0]; the same read also copies counter[15:8] into shadow.
  - CTR_ADDR+1: shadow, giving a consistent 16-bit read when low is read first.
- M1 counter:
  - Increments by 1 on each CLK with CP2_NEGEDGE=1 & M1=1 & prev_m1=0, i.e. once per fetch cycle.
  - prev_m1 is updated on each CP2_NEGEDGE.
  - 16-bit, wraps FFFF->0000.
  - Clear write and increment on the same CLK: clear wins, result 0.
- A CP2_POSEDGE arriving while in RD or WR (missing CP2_NEGEDGE) aborts the current cycle, with no write committed, and re-decodes as from IDLE.
- RESETB low mid-cycle: immediately IDLE, DB_OE=0 next CLK, any pending write dropped.
- Address bits A are only sampled at CP2_POSEDGE; changes afterwards in the cycle are ignored.

Test Plan:
- Reset, then write 8'hA5 to FF80 and 8'h3C to FFFF, read both back -> DB_O=A5 then 3C, DB_OE=1 exactly from CP2_POSEDGE+1 to CP2_NEGEDGE+1.
- Read 0x1234 (no hit) -> DB_OE=0, HIT=0 throughout; RAM unchanged.
- Issue 5 M1 fetch cycles, read FF7E then FF7F -> 8'h05 then 8'h00. Increment between the two reads -> high byte still shadow value.
- Preload counter to FFFF via 65535 fetches (or force), one more fetch -> read FF7E=00, FF7F=00.
- Write to FF7F on the same CP2_NEGEDGE as an M1 increment -> counter reads 0000.
- Assert RESETB=0 one CLK after CP2_POSEDGE of a write to FF90 -> DB_OE=0, RAM[0x10] unchanged after reset release.
